// File: rtl/prbs10_pkg.sv
// Shared constants for the PRBS10 (x^10 + x^7 + 1) checker and any matching generator.
package prbs10_pkg;
    localparam int PRBS_LEN = 10;
    localparam int TAP_A    = 10;
    localparam int TAP_B    = 7;
    localparam int ERR_W    = 16;
    localparam int BIT_W    = 24;

    typedef logic [1:0]          state_t;
    typedef logic [PRBS_LEN-1:0] prbs_state_t;

    localparam state_t ST_HUNT   = 2'd0;
    localparam state_t ST_VERIFY = 2'd1;
    localparam state_t ST_LOCKED = 2'd2;
endpackage

// File: rtl/prbs10_step.sv
// One PRBS10 step: prediction from the current register and the shifted register.
module prbs10_step
    import prbs10_pkg::*;
(
    input  prbs_state_t s,
    input  logic        bit_in,
    output logic        p,
    output prbs_state_t s_next
);
    // s[10:1] is held in bits [9:0]; tap n lives at bit n-1.
    assign p      = s[TAP_A-1] ^ s[TAP_B-1];
    assign s_next = {s[PRBS_LEN-2:0], bit_in};
endmodule

// File: rtl/prbs10_checker.sv
// PRBS10 checker: hunts for a 10-bit seed, verifies LOCK_CNT predictions, then flywheels and counts errors.
module prbs10_checker
    import prbs10_pkg::*;
#(
    parameter int LOCK_CNT  = 16,
    parameter int WINDOW    = 1024,
    parameter int ERR_LIMIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [BIT_W-1:0] bit_count,
    output logic [3:0]       leds
);
    localparam int RUN_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W = $clog2(WINDOW);
    localparam int WE_W  = $clog2(ERR_LIMIT + 1);

    state_t            state_q, state_d;
    prbs_state_t       s_q, s_d, s_next;
    logic [3:0]        fill_q, fill_d;
    logic [RUN_W-1:0]  run_q, run_d, run_inc;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [WE_W-1:0]   win_err_q, win_err_d, win_err_inc;
    logic [ERR_W-1:0]  err_count_q, err_count_d;
    logic [BIT_W-1:0]  bit_count_q, bit_count_d;
    logic              err_pulse_q, err_pulse_d;
    logic              locked_q, locked_d;
    logic [3:0]        leds_q, leds_d;
    logic              p, shift_bit, mismatch;

    // In LOCKED the register flywheels on its own prediction, so a bad input bit costs one error only.
    assign shift_bit = (state_q == ST_LOCKED) ? p : in_bit;
    assign mismatch  = in_bit ^ p;

    prbs10_step u_step (
        .s      (s_q),
        .bit_in (shift_bit),
        .p      (p),
        .s_next (s_next)
    );

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        fill_d      = fill_q;
        run_d       = run_q;
        win_d       = win_q;
        win_err_d   = win_err_q;
        err_count_d = err_count_q;
        bit_count_d = bit_count_q;
        err_pulse_d = 1'b0;
        run_inc     = run_q + RUN_W'(1);
        win_err_inc = win_err_q + WE_W'(mismatch);

        case (state_q)
            ST_HUNT: begin
                if (in_valid) begin
                    s_d = s_next;
                    if (fill_q == 4'd9) begin
                        fill_d = 4'd0;
                        if (s_next != '0) begin
                            state_d = ST_VERIFY;
                            run_d   = '0;
                        end
                    end else begin
                        fill_d = fill_q + 4'd1;
                    end
                end
            end
            ST_VERIFY: begin
                if (in_valid) begin
                    s_d = s_next;
                    if (mismatch || (s_next == '0)) begin
                        state_d = ST_HUNT;
                        fill_d  = 4'd0;
                        run_d   = '0;
                    end else begin
                        run_d = run_inc;
                        if (run_inc == RUN_W'(LOCK_CNT)) begin
                            state_d   = ST_LOCKED;
                            win_d     = '0;
                            win_err_d = '0;
                        end
                    end
                end
            end
            ST_LOCKED: begin
                if (in_valid) begin
                    s_d = s_next;
                    if (bit_count_q != '1) bit_count_d = bit_count_q + BIT_W'(1);
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
                    end
                    // The wrap bit's own error is judged against the closing window first.
                    if (win_err_inc >= WE_W'(ERR_LIMIT)) begin
                        state_d   = ST_HUNT;
                        fill_d    = 4'd0;
                        run_d     = '0;
                        win_d     = '0;
                        win_err_d = '0;
                    end else if (win_q == WIN_W'(WINDOW - 1)) begin
                        win_d     = '0;
                        win_err_d = '0;
                    end else begin
                        win_d     = win_q + WIN_W'(1);
                        win_err_d = win_err_inc;
                    end
                end
            end
            default: begin
                state_d   = ST_HUNT;
                fill_d    = 4'd0;
                run_d     = '0;
                win_d     = '0;
                win_err_d = '0;
            end
        endcase

        if (clr) begin
            err_count_d = '0;
            bit_count_d = '0;
        end

        locked_d = (state_d == ST_LOCKED);
        leds_d   = {locked_d, (err_count_d != '0), state_d};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_HUNT;
            s_q         <= '0;
            fill_q      <= 4'd0;
            run_q       <= '0;
            win_q       <= '0;
            win_err_q   <= '0;
            err_count_q <= '0;
            bit_count_q <= '0;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
            leds_q      <= 4'd0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            fill_q      <= fill_d;
            run_q       <= run_d;
            win_q       <= win_d;
            win_err_q   <= win_err_d;
            err_count_q <= err_count_d;
            bit_count_q <= bit_count_d;
            err_pulse_q <= err_pulse_d;
            locked_q    <= locked_d;
            leds_q      <= leds_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign bit_count = bit_count_q;
    assign leds      = leds_q;
endmodule

// File: tb/tb_prbs10_checker.sv
// Directed bench for prbs10_checker with an independent x^10+x^7+1 generator model.
module tb_prbs10_checker;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_bit = 1'b0;
    logic        clr = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [23:0] bit_count;
    logic [3:0]  leds;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [9:0]  gen_s;

    prbs10_checker dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clr       (clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .bit_count (bit_count),
        .leds      (leds)
    );

    always #5 clk = ~clk;

    task automatic step(input logic v, input logic b, input logic c);
        in_valid = v;
        in_bit   = b;
        clr      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic gen(output logic b);
        b     = gen_s[9] ^ gen_s[6];
        gen_s = {gen_s[8:0], b};
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        gen_s = 10'd1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %b want 0", locked); end
        n_cmp++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_err_pulse got %b want 0", err_pulse); end
        n_cmp++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL reset_err_count got %0d want 0", err_count); end
        n_cmp++; if (bit_count !== 24'd0) begin n_fail++; $display("FAIL reset_bit_count got %0d want 0", bit_count); end
        n_cmp++; if (leds !== 4'd0) begin n_fail++; $display("FAIL reset_leds got %b want 0000", leds); end
        rst = 1'b1;
        gen_s = 10'd1;
    endtask

    task automatic test_lock();
        logic b;
        logic seen_pulse;
        for (int i = 1; i <= 25; i++) begin
            gen(b); step(1'b1, b, 1'b0);
            n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early bit %0d got %b want 0", i, locked); end
        end
        gen(b); step(1'b1, b, 1'b0);
        n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_at_26 got %b want 1", locked); end
        n_cmp++; if (leds !== 4'b1010) begin n_fail++; $display("FAIL lock_leds got %b want 1010", leds); end
        seen_pulse = 1'b0;
        for (int i = 27; i <= 2000; i++) begin
            gen(b); step(1'b1, b, 1'b0);
            seen_pulse |= err_pulse;
        end
        n_cmp++; if (seen_pulse !== 1'b0) begin n_fail++; $display("FAIL lock_clean_pulse got %b want 0", seen_pulse); end
        n_cmp++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL lock_err_count got %0d want 0", err_count); end
        n_cmp++; if (bit_count !== 24'd1974) begin n_fail++; $display("FAIL lock_bit_count got %0d want 1974", bit_count); end
        n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_hold got %b want 1", locked); end
    endtask

    task automatic test_single_error();
        logic b;
        gen(b); step(1'b1, ~b, 1'b0);
        n_cmp++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL single_pulse got %b want 1", err_pulse); end
        n_cmp++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", err_count); end
        n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL single_locked got %b want 1", locked); end
        n_cmp++; if (leds !== 4'b1110) begin n_fail++; $display("FAIL single_leds got %b want 1110", leds); end
        gen(b); step(1'b1, b, 1'b0);
        n_cmp++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL single_next_pulse got %b want 0", err_pulse); end
        n_cmp++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL single_next_count got %0d want 1", err_count); end
    endtask

    task automatic test_errors_hunt();
        logic b;
        do_reset();
        for (int i = 1; i <= 26; i++) begin gen(b); step(1'b1, b, 1'b0); end
        n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL hunt_prelock got %b want 1", locked); end
        for (int i = 1; i <= 7; i++) begin gen(b); step(1'b1, ~b, 1'b0); end
        n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL hunt_after7 got %b want 1", locked); end
        n_cmp++; if (err_count !== 16'd7) begin n_fail++; $display("FAIL hunt_count7 got %0d want 7", err_count); end
        gen(b); step(1'b1, ~b, 1'b0);
        n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL hunt_after8 got %b want 0", locked); end
        n_cmp++; if (err_count !== 16'd8) begin n_fail++; $display("FAIL hunt_count8 got %0d want 8", err_count); end
        n_cmp++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL hunt_pulse8 got %b want 1", err_pulse); end
        n_cmp++; if (leds !== 4'b0100) begin n_fail++; $display("FAIL hunt_leds got %b want 0100", leds); end
        for (int i = 1; i <= 25; i++) begin
            gen(b); step(1'b1, b, 1'b0);
            n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL relock_early bit %0d got %b want 0", i, locked); end
        end
        gen(b); step(1'b1, b, 1'b0);
        n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL relock_at_26 got %b want 1", locked); end
        n_cmp++; if (err_count !== 16'd8) begin n_fail++; $display("FAIL relock_count got %0d want 8", err_count); end
    endtask

    task automatic test_stuck_zero();
        do_reset();
        for (int i = 1; i <= 500; i++) begin
            step(1'b1, 1'b0, 1'b0);
            n_cmp++; if (leds !== 4'b0000 || locked !== 1'b0) begin
                n_fail++; $display("FAIL stuck_zero bit %0d got leds=%b locked=%b want 0000/0", i, leds, locked);
            end
        end
    endtask

    task automatic test_sparse_valid();
        logic b;
        do_reset();
        for (int i = 1; i <= 26; i++) begin
            gen(b); step(1'b1, b, 1'b0);
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            if (i == 25) begin
                n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL sparse_early got %b want 0", locked); end
            end
        end
        n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL sparse_lock got %b want 1", locked); end
        gen(b); step(1'b1, b, 1'b0);
        n_cmp++; if (bit_count !== 24'd1) begin n_fail++; $display("FAIL sparse_count1 got %0d want 1", bit_count); end
        step(1'b0, ~b, 1'b0);
        step(1'b0, b, 1'b0);
        n_cmp++; if (bit_count !== 24'd1 || err_count !== 16'd0) begin
            n_fail++; $display("FAIL sparse_hold got bits=%0d errs=%0d want 1/0", bit_count, err_count);
        end
        gen(b); step(1'b1, ~b, 1'b1);
        n_cmp++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL clr_err_count got %0d want 0", err_count); end
        n_cmp++; if (bit_count !== 24'd0) begin n_fail++; $display("FAIL clr_bit_count got %0d want 0", bit_count); end
        n_cmp++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL clr_pulse got %b want 1", err_pulse); end
    endtask

    task automatic test_reset_locked();
        logic b;
        gen(b); step(1'b1, ~b, 1'b0);
        n_cmp++; if (err_count !== 16'd1 || bit_count !== 24'd1 || locked !== 1'b1) begin
            n_fail++; $display("FAIL prereset got errs=%0d bits=%0d locked=%b want 1/1/1", err_count, bit_count, locked);
        end
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL async_locked got %b want 0", locked); end
        n_cmp++; if (err_count !== 16'd0 || bit_count !== 24'd0) begin
            n_fail++; $display("FAIL async_counts got errs=%0d bits=%0d want 0/0", err_count, bit_count);
        end
        n_cmp++; if (leds !== 4'd0 || err_pulse !== 1'b0) begin
            n_fail++; $display("FAIL async_leds got leds=%b pulse=%b want 0000/0", leds, err_pulse);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            gen(b); step(1'b1, b, 1'b0);
            n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rst_relock_early bit %0d got %b want 0", i, locked); end
        end
        gen(b); step(1'b1, b, 1'b0);
        n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL rst_relock_at_26 got %b want 1", locked); end
    endtask

    initial begin
        gen_s = 10'd1;
        test_reset();
        test_lock();
        test_single_error();
        test_errors_hunt();
        test_stuck_zero();
        test_sparse_valid();
        test_reset_locked();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/prbs10_checker.md
PRBS10_CHECKER -- requirements
Module: prbs10_checker

Interface
REQ-001 Parameter LOCK_CNT, default 16, SHALL set the consecutive correct predictions required to declare lock.
REQ-002 Parameter WINDOW, default 1024, SHALL set the valid-bit length of the loss-of-lock observation window.
REQ-003 Parameter ERR_LIMIT, default 8, SHALL set the errors within one window that force loss of lock.
REQ-004 clk  in  1  SHALL be the single rising-edge clock for all state.
REQ-005 rst  in  1  SHALL be the reset: asynchronous assert, active-low, synchronous deassert handled externally.
REQ-006 in_valid  in  1  SHALL qualify in_bit; no state advances when low.
REQ-007 in_bit  in  1  SHALL be one serial bit of the x^10+x^7+1 sequence under test.
REQ-008 clr  in  1  SHALL synchronously zero err_count and bit_count.
REQ-009 locked  out  1  SHALL be high only in state LOCKED.
REQ-010 err_pulse  out  1  SHALL pulse one cycle per mismatch detected in LOCKED.
REQ-011 err_count  out  16  SHALL count LOCKED mismatches, saturating at 16'hFFFF.
REQ-012 bit_count  out  24  SHALL count valid bits checked in LOCKED, saturating at 24'hFFFFFF.
REQ-013 leds  out  4  SHALL show {locked, err_count!=0, state[1:0]}.

Function
REQ-014 Shift register s[10:1] SHALL shift left on each valid bit, new bit entering s[1]; prediction p = s[10]^s[7].
REQ-015 States SHALL be HUNT=0, VERIFY=1, LOCKED=2; encoding 3 unused, recovering to HUNT.
REQ-016 HUNT: shift in_bit into s, count fill 0..10; after the 10th valid bit go to VERIFY unless s is all-zero, then restart fill.
REQ-017 VERIFY: compare in_bit to p; shift in_bit; match increments run counter; mismatch returns to HUNT with fill=0.
REQ-018 VERIFY: when run counter reaches LOCK_CNT, state SHALL be LOCKED on the next edge; locked visible the cycle after the LOCK_CNT-th match.
REQ-019 VERIFY: s all-zero at any point SHALL force HUNT (no false lock on stuck-low input).
REQ-020 LOCKED: s SHALL shift in p, not in_bit (flywheel), so one corrupted bit yields exactly one error.
REQ-021 LOCKED: mismatch SHALL register err_pulse=1 next cycle and increment err_count and window error counter.
REQ-022 LOCKED: window counter SHALL count valid bits 0..WINDOW-1, wrapping to 0 and clearing the window error counter at wrap.
REQ-023 Window errors reaching ERR_LIMIT SHALL force HUNT next edge; err_count retained, window/run/fill counters cleared.
REQ-024 Error on the wrap bit SHALL count in the closing window before clearing.
REQ-025 clr coincident with an error or counted bit SHALL win: counters read 0 next cycle.
REQ-026 Counters SHALL hold at saturation; no wrap.
REQ-027 Outputs SHALL be registered; err_pulse latency one cycle after the offending valid bit.

Reset
REQ-028 rst low SHALL immediately set state=HUNT, s=0, all counters 0, locked=0, err_pulse=0, err_count=0, bit_count=0, leds=0.
REQ-029 Reset mid-LOCKED SHALL discard lock; reacquisition needs full 10-bit fill plus LOCK_CNT matches.

Structure
REQ-030 Shared package SHALL hold state enum, PRBS10 taps (10,7), width constants 16/24.
REQ-031 One sub-module prbs10_step SHALL compute p from s and be reusable by the generator.

Verification
REQ-032 Generator seed 10'b1, continuous valid -> locked high at cycle after 26th valid bit; err_count=0 after 2000 bits.
REQ-033 Locked, invert one bit -> single err_pulse, err_count=1, locked stays 1, next bit checks clean.
REQ-034 Locked, invert 8 bits within 1024 -> HUNT after 8th error, locked=0, err_count=8; clean stream relocks in 26 bits.
REQ-035 Constant 0 input for 500 bits -> never leaves HUNT/VERIFY, locked=0 throughout.
REQ-036 in_valid toggling 1-of-3 cycles -> lock after 26 valid bits; clr with simultaneous error -> err_count=0.
REQ-037 rst pulsed low while locked -> all outputs 0 asynchronously; relock after 26 valid bits.
